instr_cache_data_array: RTL and testbench
=========================================

// Module: instr_cache_data_array
// PURPOSE
//  Set-associative instruction-cache data store. Replaces the dummy fetch-data source.
//  Returns one fetch group from the hit way one cycle after a lookup.
//  Accepts line refills from the miss handler as a sequence of beats.
//  Sits between the fetch stage, which supplies the address and the tag-array way hit, and the refill engine.
// PARAMETERS
//  PADDR_WIDTH   `PADDR_WIDTH   physical address width
//  INSTR_WIDTH   `INSTR_WIDTH   instruction width, in bits (multiple of 8)
//  FETCH_WIDTH   `FETCH_WIDTH   instructions per fetch group; must be <= LINE_INSTRS
//  NUM_SETS      64             sets; power of 2
//  NUM_WAYS      2              ways; power of 2, >= 2
//  LINE_BYTES    32             line size; power of 2
//  BEAT_INSTRS   2              instructions per refill beat; must divide LINE_INSTRS
// PORTS
//  i_clk              in   1                         clock
//  i_rst_n            in   1                         reset; asynchronous, active-low
//  i_rd_valid         in   1                         lookup request
//  i_paddr            in   PADDR_WIDTH               lookup address
//  i_rd_way           in   log2(NUM_WAYS)            hit way, from the tag array
//  o_rd_valid         out  1                         o_data/o_data_mask valid
//  o_rd_conflict      out  1                         lookup hit the line being refilled; replay
//  o_data             out  INSTR_WIDTH x FETCH_WIDTH fetch group
//  o_data_mask        out  FETCH_WIDTH               per-slot valid
//  o_fill_ready       out  1                         refill FSM is idle
//  i_fill_start       in   1                         begin refill
//  i_fill_set         in   log2(NUM_SETS)            refill set
//  i_fill_way         in   log2(NUM_WAYS)            refill way (victim)
//  i_fill_beat_valid  in   1                         refill beat present
//  i_fill_beat_data   in   INSTR_WIDTH x BEAT_INSTRS beat payload; lowest slot = lowest address
//  i_fill_abort       in   1                         cancel the refill in progress
//  o_fill_done        out  1                         one-cycle pulse: line complete
// BEHAVIOUR
//  Derived values
//   - LINE_INSTRS = LINE_BYTES*8/INSTR_WIDTH; NUM_BEATS = LINE_INSTRS/BEAT_INSTRS.
//   - OFF_BITS = log2(LINE_BYTES).
//   - set = i_paddr[OFF_BITS+log2(NUM_SETS)-1 : OFF_BITS].
//   - start slot s = i_paddr[OFF_BITS-1 : log2(INSTR_WIDTH/8)].
//  Read (latency 1, registered outputs)
//   - Slot k = line[s+k] when s+k < LINE_INSTRS; otherwise data = 0 and mask bit = 0. No wrap into the next line.
//   - If i_rd_valid is low in cycle N: o_rd_valid = 0 in cycle N+1 and o_data holds its last value.
//  Read conflict
//   - Condition: state FILL and {set, i_rd_way} == {fill set, fill way}.
//   - Next cycle: o_rd_conflict = 1, o_rd_valid = 0, mask = 0.
//  Read/write same cycle, same entry: the read returns the old data (read-before-write).
//  Refill FSM
//   - IDLE: o_fill_ready = 1. i_fill_start latches set/way, clears beat_cnt, moves to FILL.
//   - FILL: each i_fill_beat_valid writes slots [beat_cnt*BEAT_INSTRS +: BEAT_INSTRS] and increments beat_cnt.
//     The beat with beat_cnt == NUM_BEATS-1 moves to DONE.
//     i_fill_abort moves to IDLE. An abort wins over a beat in the same cycle; that beat is not written.
//   - DONE: o_fill_done = 1 for exactly one cycle, then IDLE. o_fill_ready = 0. No conflict is flagged.
//  Ignored inputs
//   - i_fill_start outside IDLE.
//   - i_fill_beat_valid or i_fill_abort outside FILL.
//   - A beat in the same cycle as an accepted start.
//  Aborted or partial line: contents undefined; the tag array must not validate it.
//  Reset
//   - Async assert -> state IDLE, beat_cnt 0, o_rd_valid 0, o_rd_conflict 0, o_fill_done 0, o_data 0, o_data_mask 0.
//   - o_fill_ready = 1 during reset and on exit from reset.
//   - Reset mid-refill drops the refill; no o_fill_done.
//   - Storage is not reset. A read of a never-filled line returns undefined data; the tag array guarantees no hit.
// STRUCTURE
//  icache_pkg (shared):
//   - fill_state_e {IDLE, FILL, DONE}.
//   - Functions for LINE_INSTRS, NUM_BEATS and the offset/index bit ranges.
//   - fetch_group_t typedef.
//  Sub-module icache_data_bank, one per way (generate):
//   - NUM_SETS x LINE_INSTRS x INSTR_WIDTH storage.
//   - 1R1W; synchronous read of the whole line; beat-granular write enable.
//  Top level: FSM, beat counter, conflict check, way mux, fetch-group extract/mask, output registers.
// TESTING
//  1 Fill set 5 / way 1 with slot i = 0x1000+i (4 beats of 2); read paddr 0x00A0 way 1
//    -> next cycle o_rd_valid=1, data {0x1000..0x1003}, mask 4'b1111.
//  2 Read paddr 0x00B8 (s=6) -> data {0x1006, 0x1007, 0, 0}, mask 4'b0011.
//  3 Read set 5 / way 1 while beat 1 of its refill is pending -> o_rd_conflict=1, o_rd_valid=0.
//    Same lookup with way 0 -> normal data.
//  4 Abort and beat asserted together in beat 2 -> FSM in IDLE next cycle, o_fill_done never pulses, slots 4-5 unchanged.
//  5 Assert i_rst_n=0 mid-FILL (beat_cnt=2) -> all outputs at reset values immediately.
//    After release: o_fill_ready=1, and a new i_fill_start is accepted.
//  6 i_fill_start during DONE -> ignored, no second refill.
//    Back-to-back refills to different ways -> each o_fill_done is a single-cycle pulse.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, default widths and geometry helpers for the instruction cache data array
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package icache_pkg;

   localparam int DEF_PADDR_WIDTH = `PADDR_WIDTH;
   localparam int DEF_INSTR_WIDTH = `INSTR_WIDTH;
   localparam int DEF_FETCH_WIDTH = `FETCH_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   typedef logic [DEF_FETCH_WIDTH-1:0][DEF_INSTR_WIDTH-1:0] fetch_group_t;

   function automatic int line_instrs(input int line_bytes, input int instr_width);
      return (line_bytes * 8) / instr_width;
   endfunction

   function automatic int num_beats(input int line_bytes, input int instr_width, input int beat_instrs);
      return line_instrs(line_bytes, instr_width) / beat_instrs;
   endfunction

   function automatic int off_bits(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int idx_msb(input int line_bytes, input int num_sets);
      return off_bits(line_bytes) + $clog2(num_sets) - 1;
   endfunction

   function automatic int slot_lsb(input int instr_width);
      return $clog2(instr_width / 8);
   endfunction

endpackage

// File: rtl/icache_data_bank.sv
// rtl/icache_data_bank.sv - one way of line storage: whole-line synchronous read, beat-granular write
module icache_data_bank
   import icache_pkg::*;
#(
   parameter int NUM_SETS    = 64,
   parameter int LINE_INSTRS = 8,
   parameter int INSTR_WIDTH = 32,
   parameter int BEAT_INSTRS = 2,
   parameter int NUM_BEATS   = LINE_INSTRS / BEAT_INSTRS,
   parameter int SET_BITS    = $clog2(NUM_SETS),
   parameter int BEAT_BITS   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_rd_en,
   input  logic [SET_BITS-1:0]                 i_rd_set,
   output logic [LINE_INSTRS*INSTR_WIDTH-1:0]  o_rd_line,
   input  logic                                i_wr_en,
   input  logic [SET_BITS-1:0]                 i_wr_set,
   input  logic [BEAT_BITS-1:0]                i_wr_beat,
   input  logic [BEAT_INSTRS*INSTR_WIDTH-1:0]  i_wr_data
);

   localparam int BEAT_W = BEAT_INSTRS * INSTR_WIDTH;

   logic [BEAT_W-1:0]                    mem [NUM_SETS][NUM_BEATS];
   logic [LINE_INSTRS*INSTR_WIDTH-1:0]   mem_line;
   logic [LINE_INSTRS*INSTR_WIDTH-1:0]   rd_line_q;
   logic [LINE_INSTRS*INSTR_WIDTH-1:0]   rd_line_d;

   always_comb begin
      mem_line = '0;
      for (int b = 0; b < NUM_BEATS; b++) begin
         mem_line[b*BEAT_W +: BEAT_W] = mem[i_rd_set][b];
      end
   end

   // The read register only loads on a lookup so the fetch group holds between lookups.
   always_comb begin
      rd_line_d = rd_line_q;
      if (i_rd_en) begin
         rd_line_d = mem_line;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_line_q <= '0;
      end else begin
         rd_line_q <= rd_line_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem[i_wr_set][i_wr_beat] <= i_wr_data;
      end
   end

   assign o_rd_line = rd_line_q;

endmodule

// File: rtl/instr_cache_data_array.sv
// rtl/instr_cache_data_array.sv - set-associative icache data store: fetch-group lookup and beat refill FSM
module instr_cache_data_array
   import icache_pkg::*;
#(
   parameter int PADDR_WIDTH = DEF_PADDR_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
   parameter int NUM_SETS    = 64,
   parameter int NUM_WAYS    = 2,
   parameter int LINE_BYTES  = 32,
   parameter int BEAT_INSTRS = 2
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst_n,
   input  logic                                       i_rd_valid,
   input  logic [PADDR_WIDTH-1:0]                     i_paddr,
   input  logic [$clog2(NUM_WAYS)-1:0]                i_rd_way,
   output logic                                       o_rd_valid,
   output logic                                       o_rd_conflict,
   output logic [FETCH_WIDTH-1:0][INSTR_WIDTH-1:0]    o_data,
   output logic [FETCH_WIDTH-1:0]                     o_data_mask,
   output logic                                       o_fill_ready,
   input  logic                                       i_fill_start,
   input  logic [$clog2(NUM_SETS)-1:0]                i_fill_set,
   input  logic [$clog2(NUM_WAYS)-1:0]                i_fill_way,
   input  logic                                       i_fill_beat_valid,
   input  logic [BEAT_INSTRS-1:0][INSTR_WIDTH-1:0]    i_fill_beat_data,
   input  logic                                       i_fill_abort,
   output logic                                       o_fill_done
);

   localparam int LINE_INSTRS = line_instrs(LINE_BYTES, INSTR_WIDTH);
   localparam int NUM_BEATS   = num_beats(LINE_BYTES, INSTR_WIDTH, BEAT_INSTRS);
   localparam int SET_BITS    = $clog2(NUM_SETS);
   localparam int WAY_BITS    = $clog2(NUM_WAYS);
   localparam int SLOT_BITS   = $clog2(LINE_INSTRS);
   localparam int BEAT_BITS   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int IDX_LSB     = off_bits(LINE_BYTES);
   localparam int IDX_MSB     = idx_msb(LINE_BYTES, NUM_SETS);
   localparam int SLOT_LSB    = slot_lsb(INSTR_WIDTH);

   logic [SET_BITS-1:0]  rd_set;
   logic [SLOT_BITS-1:0] rd_slot;
   logic                 unused_paddr;

   assign rd_set       = i_paddr[IDX_MSB:IDX_LSB];
   assign rd_slot      = i_paddr[IDX_LSB-1:SLOT_LSB];
   assign unused_paddr = ^{i_paddr[PADDR_WIDTH-1:IDX_MSB+1], i_paddr[SLOT_LSB-1:0]};

   fill_state_e          state_q, state_d;
   logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;
   logic [SET_BITS-1:0]  fill_set_q, fill_set_d;
   logic [WAY_BITS-1:0]  fill_way_q, fill_way_d;
   logic                 beat_wr;

   // Abort is checked before the beat so an aborting beat never reaches storage.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      fill_set_d = fill_set_q;
      fill_way_d = fill_way_q;
      beat_wr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_fill_start) begin
               state_d    = FILL;
               fill_set_d = i_fill_set;
               fill_way_d = i_fill_way;
               beat_cnt_d = '0;
            end
         end
         FILL: begin
            if (i_fill_abort) begin
               state_d = IDLE;
            end else if (i_fill_beat_valid) begin
               beat_wr    = 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == BEAT_BITS'(NUM_BEATS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         fill_set_q <= '0;
         fill_way_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         fill_set_q <= fill_set_d;
         fill_way_q <= fill_way_d;
      end
   end

   assign o_fill_ready = (state_q == IDLE);
   assign o_fill_done  = (state_q == DONE);

   logic [LINE_INSTRS-1:0][INSTR_WIDTH-1:0] bank_line [NUM_WAYS];

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      icache_data_bank #(
         .NUM_SETS    (NUM_SETS),
         .LINE_INSTRS (LINE_INSTRS),
         .INSTR_WIDTH (INSTR_WIDTH),
         .BEAT_INSTRS (BEAT_INSTRS),
         .NUM_BEATS   (NUM_BEATS),
         .SET_BITS    (SET_BITS),
         .BEAT_BITS   (BEAT_BITS)
      ) u_bank (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_rd_en   (i_rd_valid),
         .i_rd_set  (rd_set),
         .o_rd_line (bank_line[w]),
         .i_wr_en   (beat_wr && (fill_way_q == WAY_BITS'(w))),
         .i_wr_set  (fill_set_q),
         .i_wr_beat (beat_cnt_q),
         .i_wr_data (i_fill_beat_data)
      );
   end

   logic rd_conflict;
   assign rd_conflict = (state_q == FILL) && (rd_set == fill_set_q) && (i_rd_way == fill_way_q);

   logic                   rd_valid_q, rd_valid_d;
   logic                   rd_conflict_q, rd_conflict_d;
   logic [FETCH_WIDTH-1:0] mask_q, mask_d;
   logic [SLOT_BITS-1:0]   slot_q, slot_d;
   logic [WAY_BITS-1:0]    way_q, way_d;

   // Slots past the end of the line are masked off; there is no wrap into the next line.
   always_comb begin
      rd_valid_d    = i_rd_valid && !rd_conflict;
      rd_conflict_d = i_rd_valid && rd_conflict;
      mask_d        = mask_q;
      slot_d        = slot_q;
      way_d         = way_q;
      if (i_rd_valid) begin
         slot_d = rd_slot;
         way_d  = i_rd_way;
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            mask_d[k] = !rd_conflict && ((int'(rd_slot) + k) < LINE_INSTRS);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_valid_q    <= 1'b0;
         rd_conflict_q <= 1'b0;
         mask_q        <= '0;
         slot_q        <= '0;
         way_q         <= '0;
      end else begin
         rd_valid_q    <= rd_valid_d;
         rd_conflict_q <= rd_conflict_d;
         mask_q        <= mask_d;
         slot_q        <= slot_d;
         way_q         <= way_d;
      end
   end

   logic [LINE_INSTRS-1:0][INSTR_WIDTH-1:0] sel_line;
   logic [SLOT_BITS-1:0]                    idx;

   always_comb begin
      sel_line = bank_line[way_q];
      idx      = '0;
      o_data   = '0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         idx = slot_q + SLOT_BITS'(k);
         if (mask_q[k]) begin
            o_data[k] = sel_line[idx];
         end
      end
   end

   assign o_rd_valid    = rd_valid_q;
   assign o_rd_conflict = rd_conflict_q;
   assign o_data_mask   = mask_q;

endmodule

// File: tb/tb_instr_cache_data_array.sv
// tb/tb_instr_cache_data_array.sv - self-checking bench for instr_cache_data_array against a line-array model
module tb_instr_cache_data_array;
   import icache_pkg::*;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_rd_valid;
   logic [31:0]     i_paddr;
   logic [0:0]      i_rd_way;
   logic            o_rd_valid;
   logic            o_rd_conflict;
   fetch_group_t    o_data;
   logic [3:0]      o_data_mask;
   logic            o_fill_ready;
   logic            i_fill_start;
   logic [5:0]      i_fill_set;
   logic [0:0]      i_fill_way;
   logic            i_fill_beat_valid;
   logic [1:0][31:0] i_fill_beat_data;
   logic            i_fill_abort;
   logic            o_fill_done;

   instr_cache_data_array dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_rd_valid        (i_rd_valid),
      .i_paddr           (i_paddr),
      .i_rd_way          (i_rd_way),
      .o_rd_valid        (o_rd_valid),
      .o_rd_conflict     (o_rd_conflict),
      .o_data            (o_data),
      .o_data_mask       (o_data_mask),
      .o_fill_ready      (o_fill_ready),
      .i_fill_start      (i_fill_start),
      .i_fill_set        (i_fill_set),
      .i_fill_way        (i_fill_way),
      .i_fill_beat_valid (i_fill_beat_valid),
      .i_fill_beat_data  (i_fill_beat_data),
      .i_fill_abort      (i_fill_abort),
      .o_fill_done       (o_fill_done)
   );

   always #5 i_clk = ~i_clk;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  mdl [2][64][8];
   logic [31:0]  fl [8];
   int           cur_set;
   int           cur_way;
   logic [127:0] last_d;
   int           kq [$];

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected fetch group: slot k is line word s+k while it stays inside the 8-word line.
   task automatic exp_group(input logic [31:0] pa, input int way, output logic [127:0] d, output logic [3:0] m);
      int set;
      int s;
      set = int'((pa >> 5) & 32'd63);
      s   = int'((pa >> 2) & 32'd7);
      d   = '0;
      m   = '0;
      for (int k = 0; k < 4; k++) begin
         if (s + k < 8) begin
            d[k*32 +: 32] = mdl[way][set][s+k];
            m[k]          = 1'b1;
         end
      end
   endtask

   task automatic rd(input logic [31:0] pa, input int way, input string tag);
      logic [127:0] d;
      logic [3:0]   m;
      exp_group(pa, way, d, m);
      i_rd_valid = 1'b1;
      i_paddr    = pa;
      i_rd_way   = 1'(way);
      tick();
      i_rd_valid = 1'b0;
      chk({tag, ".valid"}, o_rd_valid, 1);
      chk({tag, ".conflict"}, o_rd_conflict, 0);
      chk({tag, ".mask"}, o_data_mask, m);
      chk({tag, ".data"}, o_data, d);
      last_d = d;
   endtask

   task automatic hold_chk(input string tag);
      tick();
      chk({tag, ".idle_valid"}, o_rd_valid, 0);
      chk({tag, ".hold_data"}, o_data, last_d);
   endtask

   task automatic fill_start(input int set, input int way);
      chk("start.ready", o_fill_ready, 1);
      i_fill_start = 1'b1;
      i_fill_set   = 6'(set);
      i_fill_way   = 1'(way);
      tick();
      i_fill_start = 1'b0;
      cur_set      = set;
      cur_way      = way;
      chk("start.busy", o_fill_ready, 0);
   endtask

   task automatic fill_beat(input int b, input bit ab);
      i_fill_beat_valid   = 1'b1;
      i_fill_beat_data[0] = fl[2*b];
      i_fill_beat_data[1] = fl[2*b+1];
      i_fill_abort        = ab;
      tick();
      i_fill_beat_valid = 1'b0;
      i_fill_abort      = 1'b0;
      if (!ab) begin
         mdl[cur_way][cur_set][2*b]   = fl[2*b];
         mdl[cur_way][cur_set][2*b+1] = fl[2*b+1];
      end
   endtask

   task automatic full_fill(input int set, input int way, input bit start_in_done);
      fill_start(set, way);
      for (int b = 0; b < 4; b++) fill_beat(b, 1'b0);
      chk("fill.done_pulse", o_fill_done, 1);
      chk("fill.done_not_ready", o_fill_ready, 0);
      if (start_in_done) begin
         i_fill_start = 1'b1;
         i_fill_set   = 6'(set + 1);
         i_fill_way   = 1'(way);
      end
      tick();
      i_fill_start = 1'b0;
      chk("fill.done_single", o_fill_done, 0);
      chk("fill.back_idle", o_fill_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; i_rd_valid = 1'b0; i_paddr = '0; i_rd_way = '0;
      i_fill_start = 1'b0; i_fill_set = '0; i_fill_way = '0;
      i_fill_beat_valid = 1'b0; i_fill_beat_data = '0; i_fill_abort = 1'b0;
      #1;
      chk("rst.valid", o_rd_valid, 0);
      chk("rst.conflict", o_rd_conflict, 0);
      chk("rst.data", o_data, 0);
      chk("rst.mask", o_data_mask, 0);
      chk("rst.done", o_fill_done, 0);
      chk("rst.ready", o_fill_ready, 1);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("rst.exit_ready", o_fill_ready, 1);

      for (int i = 0; i < 8; i++) fl[i] = $urandom;
      full_fill(5, 0, 1'b0);

      // Directed 1 and 2: full line, then a group running off the end of the line.
      for (int i = 0; i < 8; i++) fl[i] = 32'h1000 + i;
      full_fill(5, 1, 1'b0);
      rd(32'h0000_00A0, 1, "t1");
      chk("t1.literal", o_data, {32'h1003, 32'h1002, 32'h1001, 32'h1000});
      rd(32'h0000_00B8, 1, "t2");
      chk("t2.literal", o_data, {32'h0, 32'h0, 32'h1007, 32'h1006});
      chk("t2.literal_mask", o_data_mask, 4'b0011);
      hold_chk("t2");

      // Directed 3: lookup of the line under refill replays; the other way reads normally.
      for (int i = 0; i < 8; i++) fl[i] = 32'h2000 + i;
      fill_start(5, 1);
      fill_beat(0, 1'b0);
      i_rd_valid = 1'b1; i_paddr = 32'h0000_00A0; i_rd_way = 1'b1;
      tick();
      i_rd_valid = 1'b0;
      chk("t3.conflict", o_rd_conflict, 1);
      chk("t3.conflict_valid", o_rd_valid, 0);
      chk("t3.conflict_mask", o_data_mask, 0);
      rd(32'h0000_00A0, 0, "t3_way0");
      for (int b = 1; b < 4; b++) fill_beat(b, 1'b0);
      chk("t3.done", o_fill_done, 1);
      tick();
      chk("t3.done_end", o_fill_done, 0);
      rd(32'h0000_00A0, 1, "t3_after");

      // Directed 4: abort together with beat 2 leaves slots 4-7 untouched.
      for (int i = 0; i < 8; i++) fl[i] = 32'h3000 + i;
      fill_start(5, 1);
      fill_beat(0, 1'b0);
      fill_beat(1, 1'b0);
      fill_beat(2, 1'b1);
      chk("t4.idle", o_fill_ready, 1);
      chk("t4.no_done0", o_fill_done, 0);
      tick();
      chk("t4.no_done1", o_fill_done, 0);
      rd(32'h0000_00B0, 1, "t4_old");
      chk("t4.literal", o_data, {32'h2007, 32'h2006, 32'h2005, 32'h2004});

      // Directed 5: asynchronous reset in the middle of a refill.
      rd(32'h0000_00A4, 0, "t5_pre");
      for (int i = 0; i < 8; i++) fl[i] = $urandom;
      fill_start(7, 0);
      fill_beat(0, 1'b0);
      fill_beat(1, 1'b0);
      #3;
      i_rst_n = 1'b0;
      #1;
      chk("t5.valid", o_rd_valid, 0);
      chk("t5.conflict", o_rd_conflict, 0);
      chk("t5.data", o_data, 0);
      chk("t5.mask", o_data_mask, 0);
      chk("t5.done", o_fill_done, 0);
      chk("t5.ready", o_fill_ready, 1);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("t5.exit_ready", o_fill_ready, 1);
      chk("t5.exit_done", o_fill_done, 0);
      for (int i = 0; i < 8; i++) fl[i] = $urandom;
      full_fill(7, 0, 1'b0);
      rd(32'h0000_00E8, 0, "t5_new");

      // Directed 6: start during DONE is ignored; back-to-back fills pulse once each.
      for (int i = 0; i < 8; i++) fl[i] = $urandom;
      full_fill(9, 0, 1'b1);
      for (int i = 0; i < 8; i++) fl[i] = $urandom;
      full_fill(9, 1, 1'b0);
      rd(32'h0000_0124, 0, "t6_w0");
      rd(32'h0000_0120, 1, "t6_w1");

      for (int r = 0; r < 10; r++) begin
         int s;
         int w;
         s = int'($urandom_range(63));
         w = int'($urandom_range(1));
         for (int i = 0; i < 8; i++) fl[i] = $urandom;
         full_fill(s, w, 1'b0);
         kq.push_back(w * 64 + s);
      end
      for (int r = 0; r < 40; r++) begin
         int e;
         logic [31:0] pa;
         e  = kq[$urandom_range(kq.size() - 1)];
         pa = ($urandom & 32'hFFFF_F800) | (32'(e % 64) << 5) | (32'($urandom_range(7)) << 2)
              | 32'($urandom_range(3));
         rd(pa, e / 64, "rnd");
         if ($urandom_range(3) == 0) hold_chk("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
